// File: rtl/score_pkg.sv
// score_pkg: shared constants, address helpers and state encoding for the score RAM
package score_pkg;
    localparam int SCORE_W = 16;
    localparam int ADDR_W  = 5;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_TOP_IDS   = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_TOP_SCORE = 5'd1;
    typedef enum logic {CLEAR, IDLE} state_t;
    function automatic logic [ADDR_W-1:0] player_id_addr(input logic [ADDR_W-2:0] id);
        return {id, 1'b0};
    endfunction
    function automatic logic [ADDR_W-1:0] player_score_addr(input logic [ADDR_W-2:0] id);
        return {id, 1'b1};
    endfunction
endpackage

// File: rtl/score_ram_array.sv
// score_ram_array: single-port storage, synchronous write, combinational read
// Ports: clk clock; we write enable; addr word address; din write data; dout word at addr
module score_ram_array
    import score_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [SCORE_W-1:0] din,
    output logic [SCORE_W-1:0] dout
);
    logic [SCORE_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= din;
    assign dout = mem[addr];
endmodule

// File: rtl/score_ram_responder.sv
// score_ram_responder: score RAM responder with clear sweep and read-latency pipeline
// Ports: clk clock; rst async active-low reset; scoreRAM_RW 1=write 0=read;
//        scoreRAM_Addr word address; scoreRAM_Din write data; clearAll sweep request;
//        scoreRAM_Dout registered read data; ready high while accesses are serviced
module score_ram_responder
    import score_pkg::*;
#(
    parameter int                 READ_LAT  = 2,
    parameter logic [SCORE_W-1:0] CLEAR_VAL = 16'h0000,
    parameter int                 DEPTH     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scoreRAM_RW,
    input  logic [ADDR_W-1:0]  scoreRAM_Addr,
    input  logic [SCORE_W-1:0] scoreRAM_Din,
    input  logic               clearAll,
    output logic [SCORE_W-1:0] scoreRAM_Dout,
    output logic               ready
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t             state, state_n;
    logic [ADDR_W-1:0]  cnt, cnt_n, ram_addr;
    logic [SCORE_W-1:0] ram_din, ram_dout, stage_in;
    logic               sweeping, in_range, we;
    logic [SCORE_W-1:0] pipe [READ_LAT];

    score_ram_array #(.DEPTH(DEPTH)) u_array (
        .clk (clk),
        .we  (we),
        .addr(ram_addr),
        .din (ram_din),
        .dout(ram_dout)
    );

    always_comb begin
        sweeping = state == CLEAR;
        in_range = int'(scoreRAM_Addr) < DEPTH;
        // clearAll wins over sweep completion so a late request still restarts from 0
        state_n  = clearAll ? CLEAR : (sweeping && cnt == LAST) ? IDLE : state;
        cnt_n    = (clearAll || !sweeping) ? '0 : cnt + 1'b1;
        we       = sweeping || (scoreRAM_RW == RW_WRITE && in_range);
        ram_addr = sweeping ? cnt : scoreRAM_Addr;
        ram_din  = sweeping ? CLEAR_VAL : scoreRAM_Din;
        // writes pass Din straight through so read-during-write returns new data
        stage_in = sweeping ? '0 :
                   scoreRAM_RW == RW_WRITE ? scoreRAM_Din :
                   in_range ? ram_dout : CLEAR_VAL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pipe[0] <= stage_in;
            for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign scoreRAM_Dout = pipe[READ_LAT-1];
    assign ready         = state == IDLE;
endmodule

// File: tb/tb_score_ram_responder.sv
// tb_score_ram_responder: vector table, random model comparison and clear/reset sequences
module tb_score_ram_responder;
    import score_pkg::*;
    localparam int LAT = 2;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [15:0] d;
        logic [15:0] e;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, rw = 1'b0, clr = 1'b0;
    logic [4:0]  addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        ready;
    int          total = 0, bad = 0;
    logic [15:0] mem_m [32];
    logic [15:0] hist [$];

    always #5 clk = ~clk;

    score_ram_responder #(.READ_LAT(LAT), .CLEAR_VAL(16'h0000), .DEPTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .scoreRAM_RW  (rw),
        .scoreRAM_Addr(addr),
        .scoreRAM_Din (din),
        .clearAll     (clr),
        .scoreRAM_Dout(dout),
        .ready        (ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mem_m[i] = 16'h0000;
        hist.delete();
    endtask

    // one bus access per cycle; the value a read or write-through should return is
    // queued and compared LAT cycles after it was presented
    task automatic step(input logic w, input logic [4:0] a, input logic [15:0] d, input string name);
        rw = w; addr = a; din = d;
        hist.push_back(w ? d : mem_m[a]);
        if (w) mem_m[a] = d;
        @(posedge clk); #1;
        if (hist.size() >= LAT) chk(name, dout, hist[hist.size()-LAT]);
    endtask

    vec_t tbl [14];
    int   n;

    initial begin
        tbl = '{
            '{RW_READ,  5'd2, 16'hdead, 16'h0000},
            '{RW_WRITE, 5'd7, 16'h0042, 16'h0042},
            '{RW_READ,  5'd2, 16'hdead, 16'h0000},
            '{RW_READ,  5'd7, 16'hbeef, 16'h0042},
            '{RW_WRITE, ADDR_TOP_IDS,   16'h4321, 16'h4321},
            '{RW_WRITE, ADDR_TOP_SCORE, 16'h0099, 16'h0099},
            '{RW_READ,  5'd0, 16'h1111, 16'h4321},
            '{RW_READ,  5'd1, 16'h2222, 16'h0099},
            '{RW_READ,  5'd0, 16'h3333, 16'h4321},
            '{RW_WRITE, 5'd5, 16'h0077, 16'h0077},
            '{RW_READ,  5'd5, 16'h0000, 16'h0077},
            '{RW_WRITE, 5'd5, 16'h0077, 16'h0077},
            '{RW_READ,  5'd5, 16'hffff, 16'h0077},
            '{RW_READ,  player_score_addr(4'd2), 16'h0000, 16'h0077}
        };
        tbl[13].e = 16'h0000;

        #12;
        chk("reset_ready", ready, 0);
        chk("reset_dout", dout, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ready(n);
        chk("reset_sweep_len", n, 32);
        clear_model();

        for (int i = 0; i < 32; i++) step(RW_READ, 5'(i), 16'($urandom), "post_reset_read");
        step(RW_READ, 5'd0, 16'h0, "post_reset_read");

        for (int k = 0; k < 14; k++) begin
            rw = tbl[k].w; addr = tbl[k].a; din = tbl[k].d;
            if (tbl[k].w) mem_m[tbl[k].a] = tbl[k].d;
            @(posedge clk); #1;
            if (k >= LAT - 1) chk($sformatf("vec%0d", k - LAT + 1), dout, tbl[k-LAT+1].e);
        end
        hist.delete();

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom), "rand");

        step(RW_WRITE, 5'd3, 16'h1234, "w3");
        step(RW_READ,  5'd3, 16'h0000, "r3");
        rw = RW_READ; addr = 5'd3; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_ready_drop", ready, 0);
        rw = RW_WRITE; addr = 5'd3; din = 16'hffff;
        wait_ready(n);
        chk("clr_len", n, 32);
        chk("clr_dout", dout, 0);
        clear_model();
        step(RW_READ, 5'd3, 16'h0, "clr_r3");
        step(RW_READ, 5'd7, 16'h0, "clr_r7");
        step(RW_READ, 5'd3, 16'h0, "clr_r3");
        step(RW_READ, 5'd0, 16'h0, "clr_r0");

        rw = RW_READ; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("clr2_mid_ready", ready, 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_ready(n);
        chk("clr_restart_len", 10 + n, 42);
        clear_model();

        step(RW_WRITE, 5'd9, 16'hbeef, "w9");
        step(RW_READ,  5'd9, 16'h0, "r9");
        step(RW_READ,  5'd9, 16'h0, "r9");
        #3 rst = 1'b0;
        #1;
        chk("rst_read_dout", dout, 0);
        chk("rst_read_ready", ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ready(n);
        chk("rst_read_sweep_len", n, 32);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_sweep_ready", ready, 0);
        chk("rst_sweep_dout", dout, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_ready(n);
        chk("rst_sweep_len", n, 32);
        clear_model();
        step(RW_READ, 5'd9, 16'h0, "post_rst_r9");
        step(RW_READ, 5'd31, 16'h0, "post_rst_r31");
        step(RW_READ, 5'd0, 16'h0, "post_rst_r0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
